// File: rtl/det_bareiss_nxn_pkg.sv
// Shared constants for the Bareiss determinant engine: one-hot state codes,
// parameter legality and a helper for sizing the accumulator width.
package det_bareiss_nxn_pkg;

  localparam logic [4:0] ST_I     = 5'b00001;
  localparam logic [4:0] ST_LOAD  = 5'b00010;
  localparam logic [4:0] ST_PIVOT = 5'b00100;
  localparam logic [4:0] ST_ELIM  = 5'b01000;
  localparam logic [4:0] ST_DONE  = 5'b10000;

  localparam int N_MIN = 1;
  localparam int N_MAX = 8;

  function automatic bit n_is_legal(input int n);
    return (n >= N_MIN) && (n <= N_MAX);
  endfunction

  // Hadamard-style bound: |det| < 2^(W*N) * N!, so W*N + clog2(N!) bits suffice.
  function automatic int default_acc_w(input int w, input int n);
    longint f;
    int     b;
    f = 1;
    b = 0;
    for (int i = 2; i <= n; i++) f = f * i;
    while ((longint'(1) << b) < f) b++;
    return w * n + b;
  endfunction

endpackage

// File: rtl/det_bareiss_nxn_div.sv
// Signed restoring divider for exact Bareiss quotients: a (2*ACC_W+1)-bit
// dividend over an ACC_W-bit divisor, reporting quotients that do not fit ACC_W.
module det_exact_div #(
  parameter int ACC_W = 48
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    CEN,
  input  logic                    i_start,
  input  logic signed [2*ACC_W:0] i_dividend,
  input  logic signed [ACC_W-1:0] i_divisor,
  output logic                    o_busy,
  output logic                    o_done,
  output logic signed [ACC_W-1:0] o_quot,
  output logic                    o_ovf
);

  localparam int DW = 2 * ACC_W + 1;
  localparam int QW = ACC_W + 1;
  localparam int CW = $clog2(QW + 1);

  logic [DW-1:0]    w_a_mag;
  logic [ACC_W-1:0] w_b_mag;
  logic [QW-1:0]    w_trial;
  logic [QW-1:0]    w_diff;
  logic             w_ge;
  logic [ACC_W-1:0] w_qlow;
  logic             w_fit;

  logic [ACC_W-1:0] r_rem;
  logic [QW-1:0]    r_lo;
  logic [ACC_W-1:0] r_div;
  logic             r_neg;
  logic             r_big;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  assign w_a_mag = i_dividend[DW-1] ? DW'(-i_dividend) : DW'(i_dividend);
  assign w_b_mag = i_divisor[ACC_W-1] ? ACC_W'(-i_divisor) : ACC_W'(i_divisor);

  // Dividend bits shift out of r_lo's top while quotient bits shift in at the bottom.
  assign w_trial = {r_rem, r_lo[QW-1]};
  assign w_ge    = (w_trial >= {1'b0, r_div});
  assign w_diff  = w_trial - {1'b0, r_div};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rem  <= '0;
      r_lo   <= '0;
      r_div  <= '0;
      r_neg  <= 1'b0;
      r_big  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (CEN) begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_a_mag[DW-1:QW];
        r_lo   <= w_a_mag[QW-1:0];
        r_div  <= w_b_mag;
        r_neg  <= i_dividend[DW-1] ^ i_divisor[ACC_W-1];
        r_big  <= (w_a_mag[DW-1:QW] >= w_b_mag);
        r_busy <= 1'b1;
        r_cnt  <= CW'(QW);
      end else if (r_busy) begin
        r_rem <= w_ge ? w_diff[ACC_W-1:0] : w_trial[ACC_W-1:0];
        r_lo  <= {r_lo[QW-2:0], w_ge};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  // Magnitude must be <= 2^(ACC_W-1) when negative, < 2^(ACC_W-1) otherwise.
  assign w_qlow = r_lo[ACC_W-1:0];
  assign w_fit  = !r_lo[QW-1] &&
                  (!w_qlow[ACC_W-1] || (r_neg && (w_qlow[ACC_W-2:0] == '0)));
  assign o_quot = r_neg ? -w_qlow : w_qlow;
  assign o_ovf  = r_big || !w_fit;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/det_bareiss_nxn.sv
// NxN signed determinant via fraction-free Bareiss elimination. The matrix is
// streamed row-major, reduced in place, and the bottom-right pivot gives det.
module det_bareiss_nxn
  import det_bareiss_nxn_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int ACC_W = 48
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    CEN,
  input  logic                    Start,
  input  logic                    Ack,
  input  logic                    in_valid,
  input  logic signed [W-1:0]     in_data,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] det,
  output logic                    singular,
  output logic                    ovf,
  output logic                    q_I,
  output logic                    q_Load,
  output logic                    q_Pivot,
  output logic                    q_Elim,
  output logic                    q_Done
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * ACC_W + 1;
  typedef logic [RW-1:0] idx_t;
  localparam idx_t LAST    = idx_t'(N - 1);
  localparam idx_t LAST_M1 = idx_t'(N - 2);
  localparam logic signed [ACC_W-1:0] MIN_VAL = {1'b1, {(ACC_W-1){1'b0}}};

  if (!n_is_legal(N) || (ACC_W < W)) begin : g_bad_param
    $error("det_bareiss_nxn: N must be 1..8 and ACC_W >= W");
  end

  logic signed [ACC_W-1:0] r_m [N][N];
  logic [4:0]              r_state;
  idx_t                    r_i, r_j, r_k, r_r;
  logic                    r_sign, r_wait, r_ovf_acc;
  logic signed [ACC_W-1:0] r_prev, r_det;
  logic                    r_sing, r_ovf;

  logic signed [PW-1:0]    w_ekk, w_eij, w_eik, w_ekj, w_p;
  logic                    w_p_fit;
  logic signed [ACC_W-1:0] w_in_ext, w_quot, w_new, w_neg;
  logic                    w_div_ovf, w_div_done, w_div_busy, w_div_start;
  logic                    w_new_ovf, w_step;

  assign w_in_ext = ACC_W'(in_data);

  assign w_ekk = PW'(r_m[r_k][r_k]);
  assign w_eij = PW'(r_m[r_i][r_j]);
  assign w_eik = PW'(r_m[r_i][r_k]);
  assign w_ekj = PW'(r_m[r_k][r_j]);
  assign w_p   = w_ekk * w_eij - w_eik * w_ekj;
  assign w_p_fit = (w_p[PW-1:ACC_W-1] == {(PW-ACC_W+1){w_p[ACC_W-1]}});

  // Step k=0 divides by prev=1, so its products are stored directly.
  assign w_div_start = (r_state == ST_ELIM) && (r_k != '0) && !r_wait && !w_div_busy;

  det_exact_div #(.ACC_W(ACC_W)) u_div (
    .Clk        (Clk),
    .Reset      (Reset),
    .CEN        (CEN),
    .i_start    (w_div_start),
    .i_dividend (w_p),
    .i_divisor  (r_prev),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quot     (w_quot),
    .o_ovf      (w_div_ovf)
  );

  assign w_new     = (r_k == '0) ? w_p[ACC_W-1:0] : w_quot;
  assign w_new_ovf = (r_k == '0) ? !w_p_fit : w_div_ovf;
  assign w_step    = (r_state == ST_ELIM) && ((r_k == '0) || (r_wait && w_div_done));
  assign w_neg     = -w_new;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ST_I;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_r       <= '0;
      r_sign    <= 1'b0;
      r_wait    <= 1'b0;
      r_ovf_acc <= 1'b0;
      r_prev    <= ACC_W'(1);
      r_det     <= '0;
      r_sing    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (CEN) begin
      case (r_state)
        ST_I: begin
          if (Start) begin
            r_state   <= ST_LOAD;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_r       <= '0;
            r_sign    <= 1'b0;
            r_wait    <= 1'b0;
            r_ovf_acc <= 1'b0;
            r_prev    <= ACC_W'(1);
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            r_m[r_i][r_j] <= w_in_ext;
            if (r_j == LAST) begin
              r_j <= '0;
              if (r_i == LAST) begin
                if (N == 1) begin
                  r_det   <= w_in_ext;
                  r_sing  <= (w_in_ext == '0);
                  r_ovf   <= 1'b0;
                  r_state <= ST_DONE;
                end else begin
                  r_k     <= '0;
                  r_r     <= idx_t'(1);
                  r_state <= ST_PIVOT;
                end
              end else begin
                r_i <= r_i + 1'b1;
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
          end
        end
        ST_PIVOT: begin
          if (r_m[r_k][r_k] != '0) begin
            r_i     <= idx_t'(r_k + 1'b1);
            r_j     <= idx_t'(r_k + 1'b1);
            r_state <= ST_ELIM;
          end else if (r_m[r_r][r_k] != '0) begin
            for (int c = 0; c < N; c++) begin
              r_m[r_k][idx_t'(c)] <= r_m[r_r][idx_t'(c)];
              r_m[r_r][idx_t'(c)] <= r_m[r_k][idx_t'(c)];
            end
            r_sign  <= ~r_sign;
            r_i     <= idx_t'(r_k + 1'b1);
            r_j     <= idx_t'(r_k + 1'b1);
            r_state <= ST_ELIM;
          end else if (r_r == LAST) begin
            r_det   <= '0;
            r_sing  <= 1'b1;
            r_ovf   <= r_ovf_acc;
            r_state <= ST_DONE;
          end else begin
            r_r <= r_r + 1'b1;
          end
        end
        ST_ELIM: begin
          if (w_div_start) r_wait <= 1'b1;
          if (w_step) begin
            r_wait        <= 1'b0;
            r_m[r_i][r_j] <= w_new;
            if (w_new_ovf) r_ovf_acc <= 1'b1;
            if (r_j == LAST) begin
              if (r_i == LAST) begin
                r_prev <= r_m[r_k][r_k];
                // The element being written now is M[N-1][N-1] when k = N-2.
                if (r_k == LAST_M1) begin
                  r_det   <= r_sign ? w_neg : w_new;
                  r_sing  <= (w_new == '0);
                  r_ovf   <= r_ovf_acc | w_new_ovf | (r_sign & (w_new == MIN_VAL));
                  r_state <= ST_DONE;
                end else begin
                  r_k     <= r_k + 1'b1;
                  r_r     <= idx_t'(r_k + 2'd2);
                  r_state <= ST_PIVOT;
                end
              end else begin
                r_i <= r_i + 1'b1;
                r_j <= idx_t'(r_k + 1'b1);
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (Ack) r_state <= ST_I;
        end
        default: r_state <= ST_I;
      endcase
    end
  end

  assign det      = r_det;
  assign singular = r_sing;
  assign ovf      = r_ovf;
  assign q_I      = r_state[0];
  assign q_Load   = r_state[1];
  assign q_Pivot  = r_state[2];
  assign q_Elim   = r_state[3];
  assign q_Done   = r_state[4];
  assign in_ready = q_Load;

endmodule

// File: tb/tb_det_bareiss_nxn.sv
// Directed bench: four engine configurations share clock/reset/CEN/Ack and the
// element bus; each job starts exactly one of them and checks its result.
module tb_det_bareiss_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cen, ack, in_valid;
  logic [15:0] in_data;
  logic        start_a, start_b, start_c, start_d;

  logic        rdy_a, sing_a, ovf_a, qi_a, ql_a, qp_a, qe_a, qd_a;
  logic        rdy_b, sing_b, ovf_b, qi_b, ql_b, qp_b, qe_b, qd_b;
  logic        rdy_c, sing_c, ovf_c, qi_c, ql_c, qp_c, qe_c, qd_c;
  logic        rdy_d, sing_d, ovf_d, qi_d, ql_d, qp_d, qe_d, qd_d;
  logic signed [47:0] det_a, det_b, det_d;
  logic signed [15:0] det_c;

  det_bareiss_nxn #(.N(3), .W(16), .ACC_W(48)) u_a (
    .Clk(clk), .Reset(reset), .CEN(cen), .Start(start_a), .Ack(ack),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a), .det(det_a),
    .singular(sing_a), .ovf(ovf_a), .q_I(qi_a), .q_Load(ql_a),
    .q_Pivot(qp_a), .q_Elim(qe_a), .q_Done(qd_a));

  det_bareiss_nxn #(.N(2), .W(16), .ACC_W(48)) u_b (
    .Clk(clk), .Reset(reset), .CEN(cen), .Start(start_b), .Ack(ack),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b), .det(det_b),
    .singular(sing_b), .ovf(ovf_b), .q_I(qi_b), .q_Load(ql_b),
    .q_Pivot(qp_b), .q_Elim(qe_b), .q_Done(qd_b));

  det_bareiss_nxn #(.N(4), .W(8), .ACC_W(16)) u_c (
    .Clk(clk), .Reset(reset), .CEN(cen), .Start(start_c), .Ack(ack),
    .in_valid(in_valid), .in_data(in_data[7:0]), .in_ready(rdy_c), .det(det_c),
    .singular(sing_c), .ovf(ovf_c), .q_I(qi_c), .q_Load(ql_c),
    .q_Pivot(qp_c), .q_Elim(qe_c), .q_Done(qd_c));

  det_bareiss_nxn #(.N(4), .W(8), .ACC_W(48)) u_d (
    .Clk(clk), .Reset(reset), .CEN(cen), .Start(start_d), .Ack(ack),
    .in_valid(in_valid), .in_data(in_data[7:0]), .in_ready(rdy_d), .det(det_d),
    .singular(sing_d), .ovf(ovf_d), .q_I(qi_d), .q_Load(ql_d),
    .q_Pivot(qp_d), .q_Elim(qe_d), .q_Done(qd_d));

  int errors = 0;
  int checks = 0;
  int cur = 0;
  int mat [16];

  logic sel_rdy, sel_done, sel_sing, sel_ovf, sel_qi;
  logic signed [63:0] sel_det;

  always_comb begin
    sel_rdy = rdy_a; sel_done = qd_a; sel_sing = sing_a; sel_ovf = ovf_a; sel_qi = qi_a;
    sel_det = 64'(det_a);
    case (cur)
      1: begin
        sel_rdy = rdy_b; sel_done = qd_b; sel_sing = sing_b; sel_ovf = ovf_b; sel_qi = qi_b;
        sel_det = 64'(det_b);
      end
      2: begin
        sel_rdy = rdy_c; sel_done = qd_c; sel_sing = sing_c; sel_ovf = ovf_c; sel_qi = qi_c;
        sel_det = 64'(det_c);
      end
      3: begin
        sel_rdy = rdy_d; sel_done = qd_d; sel_sing = sing_d; sel_ovf = ovf_d; sel_qi = qi_d;
        sel_det = 64'(det_d);
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int v, input bit gaps);
    int  t;
    bit  ok;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 400) begin
      @(negedge clk);
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      cen      = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = 16'(v);
      ok = in_valid && cen && sel_rdy;
      t++;
    end
    if (!ok) chk("load_timeout", 0, 1);
  endtask

  task automatic run_job(input string tag, input int which, input int n, input bit gaps, input bit poke);
    int t;
    cur = which;
    @(negedge clk);
    cen = 1'b1;
    start_a = (which == 0); start_b = (which == 1);
    start_c = (which == 2); start_d = (which == 3);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    for (int e = 0; e < n * n; e++) send(mat[e], gaps);
    @(negedge clk);
    in_valid = 1'b0;
    cen      = 1'b1;
    if (poke) begin
      t = 0;
      while (!qe_a && t < 100) begin @(negedge clk); t++; end
      chk({tag, "_elim_seen"}, 64'(qe_a), 1);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    t = 0;
    while (!sel_done && t < 4000) begin
      @(negedge clk);
      cen = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      t++;
    end
    cen = 1'b1;
    chk({tag, "_done"}, 64'(sel_done), 1);
  endtask

  task automatic finish_job(input string tag, input logic signed [63:0] exp_det, input bit check_det,
                            input bit exp_sing, input bit check_sing, input bit exp_ovf);
    if (check_det)  chk({tag, "_det"}, sel_det, exp_det);
    if (check_sing) chk({tag, "_singular"}, 64'(sel_sing), 64'(exp_sing));
    chk({tag, "_ovf"}, 64'(sel_ovf), 64'(exp_ovf));
    repeat (3) @(negedge clk);
    chk({tag, "_hold_done"}, 64'(sel_done), 1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk({tag, "_ack_to_I"}, 64'(sel_qi), 1);
    if (check_det) chk({tag, "_det_kept"}, sel_det, exp_det);
    $display("job %s: det=%0d singular=%0d ovf=%0d", tag, sel_det, sel_sing, sel_ovf);
  endtask

  initial begin
    reset = 1'b1; cen = 1'b1; ack = 1'b0; in_valid = 1'b0; in_data = '0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_qI", 64'(qi_a), 1);
    chk("rst_det", 64'(det_a), 0);
    chk("rst_ready", 64'(rdy_a), 0);
    chk("rst_sing_ovf", 64'({sing_a, ovf_a}), 0);
    chk("rst_onehot_c", 64'({qd_c, qe_c, qp_c, ql_c, qi_c}), 64'(5'b00001));

    mat = '{2, -3, 1, 2, 0, -1, 1, 4, 5, 0, 0, 0, 0, 0, 0, 0};
    run_job("a_49", 0, 3, 1'b0, 1'b0);
    finish_job("a_49", 49, 1'b1, 1'b0, 1'b1, 1'b0);

    mat = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_job("b_swap", 1, 2, 1'b0, 1'b0);
    finish_job("b_swap", -1, 1'b1, 1'b0, 1'b1, 1'b0);

    mat = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    run_job("a_ident", 0, 3, 1'b0, 1'b0);
    finish_job("a_ident", 1, 1'b1, 1'b0, 1'b1, 1'b0);

    mat = '{1, 2, 3, 2, 4, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    run_job("a_sing", 0, 3, 1'b0, 1'b0);
    finish_job("a_sing", 0, 1'b1, 1'b1, 1'b1, 1'b0);

    mat = '{1, 2, 3, 2, 4, 6, 3, 6, 10, 0, 0, 0, 0, 0, 0, 0};
    run_job("a_nopiv", 0, 3, 1'b0, 1'b0);
    finish_job("a_nopiv", 0, 1'b1, 1'b1, 1'b1, 1'b0);

    mat = '{127, 0, 0, 0, 0, 127, 0, 0, 0, 0, 127, 0, 0, 0, 0, 127};
    run_job("c_ovf", 2, 4, 1'b0, 1'b0);
    finish_job("c_ovf", 0, 1'b0, 1'b0, 1'b0, 1'b1);

    run_job("d_diag", 3, 4, 1'b0, 1'b0);
    finish_job("d_diag", 64'd260144641, 1'b1, 1'b0, 1'b1, 1'b0);

    mat = '{2, -3, 1, 2, 0, -1, 1, 4, 5, 0, 0, 0, 0, 0, 0, 0};
    run_job("a_gaps", 0, 3, 1'b1, 1'b1);
    finish_job("a_gaps", 49, 1'b1, 1'b0, 1'b1, 1'b0);

    // Abort a job mid-elimination with CEN low to show reset ignores CEN.
    cur = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int e = 0; e < 9; e++) send(mat[e], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    begin
      int t;
      t = 0;
      while (!qe_a && t < 100) begin @(negedge clk); t++; end
      chk("abort_elim_seen", 64'(qe_a), 1);
    end
    cen   = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cen   = 1'b1;
    chk("abort_qI", 64'(qi_a), 1);
    chk("abort_det", 64'(det_a), 0);
    chk("abort_ready", 64'(rdy_a), 0);
    $display("job abort: qI=%0d det=%0d in_ready=%0d", qi_a, det_a, rdy_a);

    mat = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    run_job("a_after", 0, 3, 1'b0, 1'b0);
    finish_job("a_after", 1, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
